// File: rtl/color_sensor_scanner.sv
// TCS3200-style colour front end: sequences RED/BLUE/GREEN filters, counts sensor edges over a
// fixed gate per channel and classifies each count against per-channel hit windows.
module color_sensor_scanner #(
    parameter int               CNT_W         = 16,
    parameter int               GATE_CYCLES   = 1000000,
    parameter int               SETTLE_CYCLES = 1000,
    parameter logic [1:0]       SCALE_DEFAULT = 2'b11,
    parameter logic [CNT_W-1:0] R_MIN         = '0,
    parameter logic [CNT_W-1:0] R_MAX         = '0,
    parameter logic [CNT_W-1:0] B_MIN         = '0,
    parameter logic [CNT_W-1:0] B_MAX         = '0,
    parameter logic [CNT_W-1:0] G_MIN         = '0,
    parameter logic [CNT_W-1:0] G_MAX         = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_freq,
    input  logic             start,
    input  logic             continuous,
    input  logic [1:0]       scale_sel,
    output logic [1:0]       scale,
    output logic [1:0]       filter,
    output logic             enf,
    output logic [2:0]       color,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic             frame_done,
    output logic             busy,
    output logic             overflow
);

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_GATE   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] F_RED   = 2'b00;
    localparam logic [1:0] F_BLUE  = 2'b01;
    localparam logic [1:0] F_GREEN = 2'b11;

    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (lo <= cnt) && (cnt <= hi);
    endfunction

    logic             sync1_q, sync2_q, prev_q;
    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       filter_q, filter_d;
    logic [1:0]       scale_q, scale_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hold_r_q, hold_r_d;
    logic [CNT_W-1:0] hold_b_q, hold_b_d;
    logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
    logic [CNT_W-1:0] blue_cnt_q, blue_cnt_d;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
    logic [2:0]       color_q, color_d;
    logic             overflow_q, overflow_d;
    logic             rise;
    logic             sat;
    logic [CNT_W-1:0] cnt_inc;

    // Only the synchronised rising edge is counted, never a level.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        filter_d    = filter_q;
        scale_d     = scale_q;
        cnt_d       = cnt_q;
        hold_r_d    = hold_r_q;
        hold_b_d    = hold_b_q;
        red_cnt_d   = red_cnt_q;
        blue_cnt_d  = blue_cnt_q;
        green_cnt_d = green_cnt_q;
        color_d     = color_q;
        overflow_d  = overflow_q;

        sat     = 1'b0;
        cnt_inc = cnt_q;
        if (rise) begin
            if (cnt_q == '1) sat = 1'b1;
            else             cnt_inc = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    timer_d    = SETTLE_LOAD;
                    filter_d   = F_RED;
                    scale_d    = scale_sel;
                    overflow_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            ST_SETTLE: begin
                cnt_d = '0;
                if (timer_q == '0) begin
                    state_d = ST_GATE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_GATE: begin
                cnt_d = cnt_inc;
                if (sat) overflow_d = 1'b1;
                if (timer_q == '0) begin
                    cnt_d   = '0;
                    timer_d = SETTLE_LOAD;
                    state_d = ST_SETTLE;
                    case (filter_q)
                        F_RED: begin
                            hold_r_d = cnt_inc;
                            filter_d = F_BLUE;
                        end
                        F_BLUE: begin
                            hold_b_d = cnt_inc;
                            filter_d = F_GREEN;
                        end
                        default: begin
                            // Results publish together so frame_done sees a coherent frame.
                            red_cnt_d   = hold_r_q;
                            blue_cnt_d  = hold_b_q;
                            green_cnt_d = cnt_inc;
                            color_d     = {in_window(cnt_inc, G_MIN, G_MAX),
                                           in_window(hold_b_q, B_MIN, B_MAX),
                                           in_window(hold_r_q, R_MIN, R_MAX)};
                            state_d     = ST_DONE;
                        end
                    endcase
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                if (continuous) begin
                    state_d  = ST_SETTLE;
                    timer_d  = SETTLE_LOAD;
                    filter_d = F_RED;
                    scale_d  = scale_sel;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            filter_q    <= F_RED;
            scale_q     <= SCALE_DEFAULT;
            cnt_q       <= '0;
            hold_r_q    <= '0;
            hold_b_q    <= '0;
            red_cnt_q   <= '0;
            blue_cnt_q  <= '0;
            green_cnt_q <= '0;
            color_q     <= 3'b000;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sensor_freq;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            filter_q    <= filter_d;
            scale_q     <= scale_d;
            cnt_q       <= cnt_d;
            hold_r_q    <= hold_r_d;
            hold_b_q    <= hold_b_d;
            red_cnt_q   <= red_cnt_d;
            blue_cnt_q  <= blue_cnt_d;
            green_cnt_q <= green_cnt_d;
            color_q     <= color_d;
            overflow_q  <= overflow_d;
        end
    end

    assign scale      = scale_q;
    assign filter     = filter_q;
    assign busy       = (state_q != ST_IDLE);
    assign enf        = busy;
    assign frame_done = (state_q == ST_DONE);
    assign color      = color_q;
    assign red_cnt    = red_cnt_q;
    assign blue_cnt   = blue_cnt_q;
    assign green_cnt  = green_cnt_q;
    assign overflow   = overflow_q;

endmodule
